// File: rtl/isa_pkg.sv
// Shared definitions for the 16-bit ISA: opcodes, instruction field positions
// and the loader state encoding.
package isa_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_SLL  = 4'h5;
   localparam logic [3:0] OP_SRL  = 4'h6;
   localparam logic [3:0] OP_SRA  = 4'h7;
   localparam logic [3:0] OP_LW   = 4'h8;
   localparam logic [3:0] OP_SW   = 4'h9;
   localparam logic [3:0] OP_LHB  = 4'hA;
   localparam logic [3:0] OP_LLB  = 4'hB;
   localparam logic [3:0] OP_B    = 4'hC;
   localparam logic [3:0] OP_CALL = 4'hD;
   localparam logic [3:0] OP_RET  = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

   // Bit positions of the fields inside an encoded word.
   localparam int OP_LSB   = 12;
   localparam int RD_LSB   = 8;
   localparam int RS_LSB   = 4;
   localparam int RT_LSB   = 0;
   localparam int COND_LSB = 9;
   localparam int IMM_LSB  = 0;

   localparam logic [15:0] HALT_WORD = 16'hF000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Field-bundle input stream and instruction-memory write port of the loader.
interface instr_loader_if #(
   parameter int ADDR_W = 16
) ();

   // Both channels are valid/ready: a transfer happens on a rising edge where
   // valid (in_valid / mem_we) and ready (in_ready / mem_ready) are both high;
   // the sender holds its payload stable while valid is high and ready is low.
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_op;
   logic [3:0]        in_rd;
   logic [3:0]        in_rs;
   logic [3:0]        in_rt;
   logic [11:0]       in_imm;
   logic              mem_we;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;

   modport master (
      output in_valid, in_op, in_rd, in_rs, in_rt, in_imm, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rs, in_rt, in_imm, mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/instr_encode.sv
// Combinational packer: instruction fields in, 16-bit word plus range flag out.
// Range checking exists only when INSTR_LOADER_CHECK_EN is defined.
module instr_encode
   import isa_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [3:0]  i_rd,
   input  logic [3:0]  i_rs,
   input  logic [3:0]  i_rt,
   input  logic [11:0] i_imm,
   output logic [15:0] o_word,
   output logic        o_range_err
);

   always_comb begin
      o_word              = '0;
      o_range_err         = 1'b0;
      o_word[OP_LSB +: 4] = i_op;
      case (i_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA: begin
            o_word[RD_LSB +: 4] = i_rd;
            o_word[RS_LSB +: 4] = i_rs;
            o_word[RT_LSB +: 4] = i_rt;
         end
         // Memory ops put the data register in the rd slot and the offset in rt.
         OP_LW, OP_SW: begin
            o_word[RD_LSB +: 4] = i_rt;
            o_word[RS_LSB +: 4] = i_rs;
            o_word[RT_LSB +: 4] = i_imm[3:0];
`ifdef INSTR_LOADER_CHECK_EN
            o_range_err = |i_imm[11:4];
`endif
         end
         OP_LHB, OP_LLB: begin
            o_word[RD_LSB +: 4]  = i_rd;
            o_word[IMM_LSB +: 8] = i_imm[7:0];
`ifdef INSTR_LOADER_CHECK_EN
            o_range_err = |i_imm[11:8];
`endif
         end
         OP_B: begin
            o_word[COND_LSB +: 3] = i_rd[2:0];
            o_word[IMM_LSB +: 9]  = i_imm[8:0];
`ifdef INSTR_LOADER_CHECK_EN
            o_range_err = (i_imm[11:9] != {3{i_imm[8]}}) || i_rd[3];
`endif
         end
         OP_CALL: begin
            o_word[IMM_LSB +: 12] = i_imm;
         end
         OP_RET: begin
            o_word[RS_LSB +: 4] = i_rs;
         end
         OP_HLT: begin
            o_word = HALT_WORD;
         end
         default: begin
            o_word = '0;
         end
      endcase
   end

endmodule

// File: rtl/instr_loader.sv
// Sequential instruction loader: encodes field bundles and writes them to
// consecutive memory addresses. Macro INSTR_LOADER_CHECK_EN enables range errors.
module instr_loader
   import isa_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   instr_loader_if.slave     bus,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              ovf,
   output logic [ADDR_W-1:0] word_cnt,
   output logic [1:0]        dbg_state
);

   localparam int CNT_W = $clog2(MAX_WORDS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_WORDS - 1);

   state_e            r_state;
   logic              r_we;
   logic [15:0]       r_wdata;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_word_cnt;
   logic [CNT_W-1:0]  r_acc_cnt;
   logic              r_ovf;

   logic [15:0] w_word;
   logic        w_range_err;
   logic        w_in_ready;
   logic        w_accept;
   logic        w_write;
   logic        w_wr_hs;
   logic        w_is_halt;
   logic        w_limit;
   logic        w_start_ok;

   instr_encode u_encode (
      .i_op        (bus.in_op),
      .i_rd        (bus.in_rd),
      .i_rs        (bus.in_rs),
      .i_rt        (bus.in_rt),
      .i_imm       (bus.in_imm),
      .o_word      (w_word),
      .o_range_err (w_range_err)
   );

   assign w_in_ready = (r_state == ST_RUN) && (!r_we || bus.mem_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_write    = w_accept && !w_range_err;
   assign w_wr_hs    = r_we && bus.mem_ready;
   assign w_is_halt  = (bus.in_op == OP_HLT);
   // A non-HALT word that fills the last slot still gets written, then we stop.
   assign w_limit    = w_write && !w_is_halt && (r_acc_cnt == LAST_IDX);
   assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start_ok) begin
                  r_state <= ST_RUN;
                  r_ovf   <= 1'b0;
               end
            end
            ST_RUN: begin
               if (w_write && w_is_halt) begin
                  r_state <= ST_STOP;
               end else if (w_limit) begin
                  r_state <= ST_STOP;
                  r_ovf   <= 1'b1;
               end
            end
            ST_STOP: begin
               if (!r_we || bus.mem_ready) begin
                  r_state <= ST_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // r_addr always points at the word in (or next into) the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_addr     <= '0;
         r_word_cnt <= '0;
         r_acc_cnt  <= '0;
      end else begin
         if (w_start_ok) begin
            r_addr     <= base_addr;
            r_word_cnt <= '0;
            r_acc_cnt  <= '0;
         end else if (w_wr_hs) begin
            r_addr     <= r_addr + 1'b1;
            r_word_cnt <= r_word_cnt + 1'b1;
         end
         if (w_write) begin
            r_we      <= 1'b1;
            r_wdata   <= w_word;
            r_acc_cnt <= r_acc_cnt + 1'b1;
         end else if (w_wr_hs) begin
            r_we <= 1'b0;
         end
      end
   end

`ifdef INSTR_LOADER_CHECK_EN
   logic r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_start_ok) begin
         r_err <= 1'b0;
      end else if (w_accept && w_range_err) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign busy          = (r_state == ST_RUN) || (r_state == ST_STOP);
   assign done          = (r_state == ST_DONE);
   assign ovf           = r_ovf;
   assign word_cnt      = r_word_cnt;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: encoding, backpressure, range, overflow,
// address wrap and mid-run reset.
module tb_instr_loader;

   logic        clk;
   logic        rst_n;
   logic        start, start2;
   logic [15:0] base_addr, base2;
   logic        busy, done, err, ovf;
   logic        busy2, done2, err2, ovf2;
   logic [15:0] word_cnt, word_cnt2;
   logic [1:0]  dbg_state, dbg_state2;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   instr_loader_if #(.ADDR_W(16)) bus ();
   instr_loader_if #(.ADDR_W(16)) bus2 ();

   instr_loader #(.ADDR_W(16), .MAX_WORDS(1024)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .bus(bus.slave), .busy(busy), .done(done), .err(err), .ovf(ovf),
      .word_cnt(word_cnt), .dbg_state(dbg_state)
   );

   instr_loader #(.ADDR_W(16), .MAX_WORDS(4)) u_dut_ovf (
      .clk(clk), .rst_n(rst_n), .start(start2), .base_addr(base2),
      .bus(bus2.slave), .busy(busy2), .done(done2), .err(err2), .ovf(ovf2),
      .word_cnt(word_cnt2), .dbg_state(dbg_state2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // scoreboard: every write handshake of the main DUT must match the queue head
   always @(negedge clk) begin
      if (rst_n && bus.mem_we && bus.mem_ready) begin
         if (exp_q.size() == 0) chk("unexpected_write", {bus.mem_addr, bus.mem_wdata}, 32'hxxxx_xxxx);
         else chk("write", {bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
      end
   end

   // driver tasks
   task automatic pulse_start(input logic [15:0] base);
      @(posedge clk); #1;
      start = 1'b1; base_addr = base;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [11:0] imm);
      bit got;
      bus.in_op = op; bus.in_rd = rd; bus.in_rs = rs; bus.in_rt = rt; bus.in_imm = imm;
      bus.in_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (bus.in_ready) got = 1'b1;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (!got) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int n_acc, n_wr;
      bit acc;
      logic [3:0] r;

      rst_n = 1'b0; start = 1'b0; start2 = 1'b0; base_addr = '0; base2 = '0;
      bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs = '0;
      bus.in_rt = '0; bus.in_imm = '0; bus.mem_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.in_op = '0; bus2.in_rd = '0; bus2.in_rs = '0;
      bus2.in_rt = '0; bus2.in_imm = '0; bus2.mem_ready = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_addr_data", {bus.mem_addr, bus.mem_wdata}, 0);
      chk("rst_flags", {busy, done, err, ovf}, 0);
      chk("rst_word_cnt", word_cnt, 0);
      chk("rst_state", dbg_state, 0);
      rst_n = 1'b1;

      // encoding sweep
      pulse_start(16'h0040);
      chk("start_busy", busy, 1);
      chk("start_word_cnt", word_cnt, 0);
      exp_q.push_back(32'h0040_0312); exp_q.push_back(32'h0041_8524);
      exp_q.push_back(32'h0042_A7AB); exp_q.push_back(32'h0043_C7FE);
      exp_q.push_back(32'h0044_D123); exp_q.push_back(32'h0045_E0F0);
      exp_q.push_back(32'h0046_F000);
      send(4'h0, 4'd3, 4'd1, 4'd2, 12'h000);
      send(4'h8, 4'd0, 4'd2, 4'd5, 12'h004);
      send(4'hA, 4'd7, 4'd0, 4'd0, 12'h0AB);
      send(4'hC, 4'd3, 4'd0, 4'd0, 12'hFFE);
      send(4'hD, 4'd0, 4'd0, 4'd0, 12'h123);
      send(4'hE, 4'd0, 4'd15, 4'd0, 12'h000);
      send(4'hF, 4'd0, 4'd0, 4'd0, 12'h000);
      chk("halt_in_ready_drop", bus.in_ready, 0);
      chk("halt_done_not_yet", done, 0);
      chk("halt_pending", {bus.mem_we, bus.mem_wdata}, {16'h0001, 16'hF000});
      @(posedge clk); #1;
      chk("done_after_halt", {done, busy}, 2'b10);
      chk("sweep_word_cnt", word_cnt, 7);
      chk("sweep_flags", {err, ovf}, 0);
      chk("sweep_queue", exp_q.size(), 0);

      // backpressure
      pulse_start(16'h0100);
      bus.mem_ready = 1'b0;
      exp_q.push_back(32'h0100_0123); exp_q.push_back(32'h0101_1456);
      exp_q.push_back(32'h0102_F000);
      send(4'h0, 4'd1, 4'd2, 4'd3, 12'h000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_hold", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 16'h0100, 16'h0123});
         @(posedge clk); #1;
      end
      bus.mem_ready = 1'b1;
      send(4'h1, 4'd4, 4'd5, 4'd6, 12'h000);
      send(4'hF, 4'd0, 4'd0, 4'd0, 12'h000);
      wait_done();
      chk("bp_word_cnt", word_cnt, 3);
      chk("bp_queue", exp_q.size(), 0);

      // range error
      pulse_start(16'h0200);
`ifdef INSTR_LOADER_CHECK_EN
      send(4'hA, 4'd1, 4'd0, 4'd0, 12'h1AB);
      chk("range_err_set", err, 1);
      chk("range_no_write", bus.mem_we, 0);
      exp_q.push_back(32'h0200_0312); exp_q.push_back(32'h0201_F000);
      send(4'h0, 4'd3, 4'd1, 4'd2, 12'h000);
      @(posedge clk); #1;
      chk("range_word_cnt", word_cnt, 1);
      send(4'hF, 4'd0, 4'd0, 4'd0, 12'h000);
      wait_done();
      chk("range_err_sticky", err, 1);
`else
      exp_q.push_back(32'h0200_A1AB); exp_q.push_back(32'h0201_0312);
      exp_q.push_back(32'h0202_F000);
      send(4'hA, 4'd1, 4'd0, 4'd0, 12'h1AB);
      chk("trunc_no_err", err, 0);
      send(4'h0, 4'd3, 4'd1, 4'd2, 12'h000);
      send(4'hF, 4'd0, 4'd0, 4'd0, 12'h000);
      wait_done();
      chk("trunc_word_cnt", word_cnt, 3);
`endif
      chk("range_queue", exp_q.size(), 0);

      // overflow on the MAX_WORDS=4 instance
      @(posedge clk); #1;
      start2 = 1'b1; base2 = 16'h0000;
      @(posedge clk); #1;
      start2 = 1'b0;
      n_acc = 0; n_wr = 0;
      bus2.in_op = 4'h0; bus2.in_rd = 4'd1; bus2.in_rs = 4'd1; bus2.in_rt = 4'd1;
      bus2.in_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus2.mem_we && bus2.mem_ready) begin
            r = 4'(n_wr + 1);
            chk("ovf_write", {bus2.mem_addr, bus2.mem_wdata}, {16'(n_wr), 4'h0, r, r, r});
            n_wr++;
         end
         acc = bus2.in_valid && bus2.in_ready;
         @(posedge clk); #1;
         if (acc) begin
            n_acc++;
            r = 4'(n_acc + 1);
            bus2.in_rd = r; bus2.in_rs = r; bus2.in_rt = r;
         end
      end
      bus2.in_valid = 1'b0;
      chk("ovf_accepts", n_acc, 4);
      chk("ovf_writes", n_wr, 4);
      chk("ovf_flags", {ovf2, done2, busy2, err2}, 4'b1100);
      chk("ovf_word_cnt", word_cnt2, 4);
      chk("ovf_in_ready", bus2.in_ready, 0);

      // address wrap
      pulse_start(16'hFFFF);
      exp_q.push_back(32'hFFFF_0111); exp_q.push_back(32'h0000_1222);
      exp_q.push_back(32'h0001_F000);
      send(4'h0, 4'd1, 4'd1, 4'd1, 12'h000);
      send(4'h1, 4'd2, 4'd2, 4'd2, 12'h000);
      send(4'hF, 4'd0, 4'd0, 4'd0, 12'h000);
      wait_done();
      chk("wrap_word_cnt", word_cnt, 3);
      chk("wrap_queue", exp_q.size(), 0);

      // reset mid-run with a pending write
      pulse_start(16'h0300);
      bus.mem_ready = 1'b0;
      send(4'h0, 4'd9, 4'd9, 4'd9, 12'h000);
      chk("pre_rst_pending", bus.mem_we, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_mem", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
      chk("midrst_flags", {busy, done, err, ovf, bus.in_ready}, 0);
      chk("midrst_state_cnt", {dbg_state, word_cnt}, 0);
      bus.mem_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("midrst_no_write", bus.mem_we, 0);
      end
      rst_n = 1'b1;
      pulse_start(16'h0010);
      exp_q.push_back(32'h0010_0312); exp_q.push_back(32'h0011_F000);
      send(4'h0, 4'd3, 4'd1, 4'd2, 12'h000);
      send(4'hF, 4'd0, 4'd0, 4'd0, 12'h000);
      wait_done();
      chk("after_rst_word_cnt", word_cnt, 2);
      chk("final_queue", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
